palette_fader: RTL and testbench

- Parametrised, run-time writable colour palette with a frame-synchronous fade-in/fade-out engine.
- Sits between the sprite/background index path and the VGA colour outputs; one instance replaces per-screen fixed palettes.
- Screen loaders write the palette entries. The game FSM triggers fades on screen transitions, such as fading out to the end screen.

---
 rtl/palette_fader_pkg.sv | 31 +++
 rtl/palette_fader_fade_ctrl.sv | 116 +++++++++++
 rtl/palette_fader.sv | 109 ++++++++++
 tb/tb_palette_fader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_fader_pkg.sv
// Shared types and the channel scaling helper for the palette fader.
package palette_fader_pkg;

    typedef enum logic [1:0] {
        DARK,
        FADE_IN,
        SHOWN,
        FADE_OUT
    } fade_state_t;

    localparam int CHAN_W_DEF = 4;
    localparam int SCALE_W    = 16;

    typedef struct packed {
        logic [CHAN_W_DEF-1:0] r;
        logic [CHAN_W_DEF-1:0] g;
        logic [CHAN_W_DEF-1:0] b;
    } rgb_t;

    // (c * lvl) >> lvl_w, truncated; callers narrow the result to their channel width.
    function automatic logic [SCALE_W-1:0] scale_chan(
        input logic [SCALE_W-1:0] c,
        input logic [SCALE_W-1:0] lvl,
        input int unsigned        lvl_w
    );
        logic [2*SCALE_W-1:0] prod;
        prod       = {{SCALE_W{1'b0}}, c} * {{SCALE_W{1'b0}}, lvl};
        scale_chan = SCALE_W'(prod >> lvl_w);
    endfunction

endpackage

// File: rtl/palette_fader_fade_ctrl.sv
// Fade FSM: frame-tick step counter, brightness level, busy and done flags.
module fade_ctrl
    import palette_fader_pkg::*;
#(
    parameter int LEVEL_W         = 4,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_tick,
    input  logic             fade_in,
    input  logic             fade_out,
    output logic             fade_busy,
    output logic             fade_done,
    output logic [LEVEL_W:0] level
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [LEVEL_W:0] LVL_MAX   = {1'b1, {LEVEL_W{1'b0}}};
    localparam logic [LEVEL_W:0] LVL_NEAR  = LVL_MAX - 1'b1;
    localparam logic [LEVEL_W:0] LVL_ONE   = {{LEVEL_W{1'b0}}, 1'b1};

    fade_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEVEL_W:0] level_q, level_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        done_d  = 1'b0;
        case (state_q)
            DARK: begin
                if (fade_in && !fade_out) begin
                    state_d = FADE_IN;
                    cnt_d   = '0;
                end
            end
            SHOWN: begin
                if (fade_out) begin
                    state_d = FADE_OUT;
                    cnt_d   = '0;
                end
            end
            FADE_IN: begin
                if (fade_out) begin
                    state_d = FADE_OUT;
                    cnt_d   = '0;
                end else if (level_q == LVL_MAX) begin
                    // only reachable after reversing at the top of a fade-out
                    state_d = SHOWN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        level_d = level_q + 1'b1;
                        if (level_q == LVL_NEAR) begin
                            state_d = SHOWN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FADE_OUT: begin
                if (fade_in && !fade_out) begin
                    state_d = FADE_IN;
                    cnt_d   = '0;
                end else if (level_q == '0) begin
                    state_d = DARK;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        level_d = level_q - 1'b1;
                        if (level_q == LVL_ONE) begin
                            state_d = DARK;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = DARK;
                cnt_d   = '0;
                level_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= DARK;
            cnt_q   <= '0;
            level_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            done_q  <= done_d;
        end
    end

    assign fade_busy = (state_q == FADE_IN) || (state_q == FADE_OUT);
    assign fade_done = done_q;
    assign level     = level_q;

endmodule

// File: rtl/palette_fader.sv
// Writable colour palette with a 2-stage lookup/fade pipeline driven by fade_ctrl.
module palette_fader
    import palette_fader_pkg::*;
#(
    parameter int INDEX_W         = 4,
    parameter int CHAN_W          = 4,
    parameter int LEVEL_W         = 4,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [INDEX_W-1:0]    index,
    input  logic                  index_valid,
    output logic [CHAN_W-1:0]     red,
    output logic [CHAN_W-1:0]     green,
    output logic [CHAN_W-1:0]     blue,
    output logic                  rgb_valid,
    input  logic                  wr_en,
    input  logic [INDEX_W-1:0]    wr_addr,
    input  logic [3*CHAN_W-1:0]   wr_data,
    input  logic                  frame_tick,
    input  logic                  fade_in,
    input  logic                  fade_out,
    output logic                  fade_busy,
    output logic                  fade_done,
    output logic [LEVEL_W:0]      level
);

    localparam int DEPTH = 2 ** INDEX_W;
    localparam int ENT_W = 3 * CHAN_W;

    logic [ENT_W-1:0]  pal_q [DEPTH];
    logic [ENT_W-1:0]  pal_d [DEPTH];

    logic [ENT_W-1:0]  ent_p1_q, ent_p1_d;
    logic [LEVEL_W:0]  lvl_p1_q, lvl_p1_d;
    logic              vld_p1_q, vld_p1_d;

    logic [CHAN_W-1:0] red_p2_q, red_p2_d;
    logic [CHAN_W-1:0] grn_p2_q, grn_p2_d;
    logic [CHAN_W-1:0] blu_p2_q, blu_p2_d;
    logic              vld_p2_q, vld_p2_d;

    fade_ctrl #(
        .LEVEL_W         (LEVEL_W),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_ctrl (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .fade_in    (fade_in),
        .fade_out   (fade_out),
        .fade_busy  (fade_busy),
        .fade_done  (fade_done),
        .level      (level)
    );

    always_comb begin
        pal_d = pal_q;
        if (wr_en) begin
            pal_d[wr_addr] = wr_data;
        end
    end

    // Stage 1: palette read (old contents on a same-cycle write) and level snapshot
    always_comb begin
        ent_p1_d = pal_q[index];
        lvl_p1_d = level;
        vld_p1_d = index_valid;
    end

    // Stage 2: per-channel brightness scaling
    always_comb begin
        red_p2_d = CHAN_W'(scale_chan(SCALE_W'(ent_p1_q[ENT_W-1 -: CHAN_W]), SCALE_W'(lvl_p1_q), LEVEL_W));
        grn_p2_d = CHAN_W'(scale_chan(SCALE_W'(ent_p1_q[2*CHAN_W-1 -: CHAN_W]), SCALE_W'(lvl_p1_q), LEVEL_W));
        blu_p2_d = CHAN_W'(scale_chan(SCALE_W'(ent_p1_q[CHAN_W-1:0]), SCALE_W'(lvl_p1_q), LEVEL_W));
        vld_p2_d = vld_p1_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal_q[i] <= '0;
            end
            ent_p1_q <= '0;
            lvl_p1_q <= '0;
            vld_p1_q <= 1'b0;
            red_p2_q <= '0;
            grn_p2_q <= '0;
            blu_p2_q <= '0;
            vld_p2_q <= 1'b0;
        end else begin
            pal_q    <= pal_d;
            ent_p1_q <= ent_p1_d;
            lvl_p1_q <= lvl_p1_d;
            vld_p1_q <= vld_p1_d;
            red_p2_q <= red_p2_d;
            grn_p2_q <= grn_p2_d;
            blu_p2_q <= blu_p2_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    assign red       = red_p2_q;
    assign green     = grn_p2_q;
    assign blue      = blu_p2_q;
    assign rgb_valid = vld_p2_q;

endmodule

// File: tb/tb_palette_fader.sv
// Self-checking bench for palette_fader: table-driven lookups plus fade/reset sequences.
module tb_palette_fader;

    localparam int INDEX_W = 4;
    localparam int CHAN_W  = 4;
    localparam int LEVEL_W = 4;
    localparam int FPS     = 2;

    logic                 Clk;
    logic                 Reset_n;
    logic [INDEX_W-1:0]   index;
    logic                 index_valid;
    logic [CHAN_W-1:0]    red, green, blue;
    logic                 rgb_valid;
    logic                 wr_en;
    logic [INDEX_W-1:0]   wr_addr;
    logic [3*CHAN_W-1:0]  wr_data;
    logic                 frame_tick, fade_in, fade_out;
    logic                 fade_busy, fade_done;
    logic [LEVEL_W:0]     level;

    palette_fader #(
        .INDEX_W(INDEX_W), .CHAN_W(CHAN_W), .LEVEL_W(LEVEL_W), .FRAMES_PER_STEP(FPS)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .index(index), .index_valid(index_valid),
        .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_tick(frame_tick), .fade_in(fade_in), .fade_out(fade_out),
        .fade_busy(fade_busy), .fade_done(fade_done), .level(level)
    );

    typedef struct {
        int          due;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        int          lvl;
        int          idx;
        logic [11:0] rgb;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   total, bad, cycle, done_cnt;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic check_out();
        exp_t e;
        logic [11:0] got;
        if (fade_done) done_cnt++;
        got = {red, green, blue};
        if (rgb_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got rgb=%03h at cycle %0d, expected no valid output", got, cycle);
            end else begin
                e = sb.pop_front();
                if (e.due != cycle || got != e.rgb) begin
                    bad++;
                    $display("FAIL pixel: got rgb=%03h at cycle %0d, expected rgb=%03h at cycle %0d",
                             got, cycle, e.rgb, e.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cycle) begin
            total++;
            bad++;
            e = sb.pop_front();
            $display("FAIL missing_valid: got rgb_valid=0 at cycle %0d, expected rgb=%03h", cycle, e.rgb);
        end
    endtask

    task automatic clk_cycle();
        @(negedge Clk);
        check_out();
        @(posedge Clk);
        #1;
        cycle++;
    endtask

    task automatic pixel(input int idx, input logic [11:0] rgb);
        exp_t e;
        index       = INDEX_W'(idx);
        index_valid = 1'b1;
        e.due = cycle + 2;
        e.rgb = rgb;
        sb.push_back(e);
        clk_cycle();
        index_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) clk_cycle();
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic write_entry(input int addr, input logic [11:0] data);
        wr_en   = 1'b1;
        wr_addr = INDEX_W'(addr);
        wr_data = data;
        clk_cycle();
        wr_en   = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        clk_cycle();
        frame_tick = 1'b0;
        clk_cycle();
    endtask

    task automatic pulse(input logic fi, input logic fo);
        fade_in  = fi;
        fade_out = fo;
        clk_cycle();
        fade_in  = 1'b0;
        fade_out = 1'b0;
    endtask

    task automatic apply_table(input int lvl);
        chk("table_level", int'(level), lvl);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].lvl == lvl) pixel(vecs[i].idx, vecs[i].rgb);
        end
        drain();
    endtask

    initial begin
        vecs[0] = '{0,  5, 12'h000};
        vecs[1] = '{0,  3, 12'h000};
        vecs[2] = '{8,  5, 12'h751};
        vecs[3] = '{8,  3, 12'h641};
        vecs[4] = '{8,  7, 12'h777};
        vecs[5] = '{8,  1, 12'h011};
        vecs[6] = '{16, 3, 12'hC92};
        vecs[7] = '{16, 5, 12'hFB3};
        vecs[8] = '{16, 7, 12'hFFF};
        vecs[9] = '{16, 1, 12'h123};

        total = 0; bad = 0; cycle = 0; done_cnt = 0;
        Reset_n = 1'b0; index = '0; index_valid = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        frame_tick = 1'b0; fade_in = 1'b0; fade_out = 1'b0;

        repeat (2) clk_cycle();
        chk("rst_rgb", int'({red, green, blue}), 0);
        chk("rst_valid", int'(rgb_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_busy", int'(fade_busy), 0);
        chk("rst_done", int'(fade_done), 0);
        Reset_n = 1'b1;
        clk_cycle();

        write_entry(3, 12'hC92);
        write_entry(5, 12'hFB3);
        write_entry(2, 12'h190);
        write_entry(7, 12'hFFF);
        write_entry(1, 12'h123);

        // fade_out and ticks while dark are ignored
        pulse(1'b0, 1'b1);
        chk("dark_fo_busy", int'(fade_busy), 0);
        repeat (3) tick();
        chk("dark_level", int'(level), 0);
        apply_table(0);

        // fade in halfway, then to full brightness
        pulse(1'b1, 1'b0);
        chk("fi_busy", int'(fade_busy), 1);
        repeat (16) tick();
        chk("fi_half_done", done_cnt, 0);
        apply_table(8);
        repeat (16) tick();
        chk("fi_done_once", done_cnt, 1);
        chk("fi_level", int'(level), 16);
        chk("shown_busy", int'(fade_busy), 0);
        apply_table(16);

        // write and read the same entry in one cycle
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 12'h0F0;
        pixel(2, 12'h190);
        wr_en = 1'b0;
        pixel(2, 12'h0F0);
        drain();

        // idle ticks and fade_in while shown
        repeat (100) tick();
        chk("shown_level", int'(level), 16);
        chk("shown_no_done", done_cnt, 1);
        pulse(1'b1, 1'b0);
        chk("shown_fi_ign", int'(fade_busy), 0);

        // simultaneous requests: fade_out wins
        pulse(1'b1, 1'b1);
        chk("both_busy", int'(fade_busy), 1);
        repeat (2) tick();
        chk("both_dir", int'(level), 15);
        repeat (30) tick();
        chk("fo_level", int'(level), 0);
        chk("fo_busy", int'(fade_busy), 0);
        chk("fo_done", done_cnt, 2);

        // reversal mid fade-in with a partly counted step
        pulse(1'b1, 1'b0);
        repeat (13) tick();
        chk("rev_start", int'(level), 6);
        pulse(1'b0, 1'b1);
        chk("rev_busy", int'(fade_busy), 1);
        tick();
        chk("rev_cnt_clr", int'(level), 6);
        tick();
        chk("rev_down", int'(level), 5);
        chk("rev_no_done", done_cnt, 2);

        // reverse again up to level 9, then reset with pixels in flight
        pulse(1'b1, 1'b0);
        repeat (8) tick();
        chk("pre_rst_level", int'(level), 9);
        pixel(3, 12'h651);
        pixel(5, 12'h861);
        chk("inflight_valid", int'(rgb_valid), 1);
        chk("inflight_red", int'(red), 6);
        #2;
        Reset_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_rgb", int'({red, green, blue}), 0);
        chk("arst_valid", int'(rgb_valid), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_busy", int'(fade_busy), 0);
        repeat (2) clk_cycle();
        Reset_n = 1'b1;
        clk_cycle();

        // palette must be cleared: fade to full and read old entries
        pulse(1'b1, 1'b0);
        repeat (32) tick();
        chk("post_level", int'(level), 16);
        chk("post_done", done_cnt, 3);
        pixel(3, 12'h000);
        pixel(5, 12'h000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
